// File: rtl/uart_bus_host.sv
// rtl/uart_bus_host.sv - bus initiator driving the UART register map from TX/RX byte streams
// Optional stall abort is compiled in when UART_HOST_TIMEOUT_EN is defined.
module uart_bus_host #(
  parameter int TxHighWater   = 6,
  parameter int TimeoutCycles = 1024
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        cfg_start,
  input  logic [15:0] cfg_rate,
  input  logic        cfg_flow,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic [31:0] addr,
  output logic        wen,
  output logic        ren,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        request_stall,
  input  logic        bus_error,
  output logic        ready,
  output logic        rx_err,
  output logic        err,
  output logic        timeout
);
  localparam logic [31:0] A_RX_DATA  = 32'd0;
  localparam logic [31:0] A_TX_DATA  = 32'd4;
  localparam logic [31:0] A_RX_STATE = 32'd8;
  localparam logic [31:0] A_TX_STATE = 32'd12;
  localparam logic [31:0] A_BAUD     = 32'd16;
  localparam logic [31:0] A_BUF_CLR  = 32'd20;
  localparam logic [31:0] A_FLOW     = 32'd24;
  localparam logic [2:0]  TX_HIGH    = 3'(TxHighWater);

  typedef enum logic [3:0] {
    RESET_WAIT, CLR, RATE, FLOW, POLL_RX, READ_RX, HOLD_RX, POLL_TX, WRITE_TX
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        wen_q, wen_d, ren_q, ren_d;
  logic [7:0]  hold_q, hold_d;
  logic        ready_q, ready_d, rx_err_q, rx_err_d, err_q, err_d;
  logic        req, done;
  logic        unused_rdata;

  assign req          = wen_q | ren_q;
  assign done         = req & ~request_stall;
  assign unused_rdata = ^rdata[31:8];

  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign wen      = wen_q;
  assign ren      = ren_q;
  assign rx_valid = (state_q == HOLD_RX);
  assign rx_data  = hold_q;
  assign ready    = ready_q;
  assign rx_err   = rx_err_q;
  assign err      = err_q;

`ifdef UART_HOST_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TimeoutCycles - 1);
  logic [15:0] tcnt_q, tcnt_d;
  logic        timeout_q, timeout_d;
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  localparam int unused_timeout_cycles = TimeoutCycles;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q  <= RESET_WAIT;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
      hold_q   <= '0;
      ready_q  <= 1'b0;
      rx_err_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      hold_q   <= hold_d;
      ready_q  <= ready_d;
      rx_err_q <= rx_err_d;
      err_q    <= err_d;
    end
  end

  // Each access state loads the request in its first cycle and leaves on completion.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wen_d    = wen_q;
    ren_d    = ren_q;
    hold_d   = hold_q;
    ready_d  = ready_q;
    rx_err_d = rx_err_q;
    err_d    = err_q;
    tx_ready = 1'b0;
`ifdef UART_HOST_TIMEOUT_EN
    tcnt_d    = tcnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      CLR: begin
        if (!req) begin
          addr_d  = A_BUF_CLR;
          wdata_d = 32'd1;
          wen_d   = 1'b1;
        end else if (done) begin
          wen_d   = 1'b0;
          state_d = RATE;
        end
      end
      RATE: begin
        if (!req) begin
          addr_d  = A_BAUD;
          wdata_d = {16'b0, cfg_rate};
          wen_d   = 1'b1;
        end else if (done) begin
          wen_d   = 1'b0;
          state_d = FLOW;
        end
      end
      FLOW: begin
        if (!req) begin
          addr_d  = A_FLOW;
          wdata_d = {31'b0, cfg_flow};
          wen_d   = 1'b1;
        end else if (done) begin
          wen_d   = 1'b0;
          ready_d = 1'b1;
          state_d = POLL_RX;
        end
      end
      POLL_RX: begin
        if (!req) begin
          addr_d = A_RX_STATE;
          ren_d  = 1'b1;
        end else if (done) begin
          ren_d   = 1'b0;
          // An idle TX side is skipped here so the empty loop costs two cycles per poll.
          state_d = tx_valid ? POLL_TX : POLL_RX;
          if (!bus_error) begin
            if (rdata[4]) rx_err_d = 1'b1;
            if (rdata[3] || (rdata[2:0] != 3'd0)) state_d = READ_RX;
          end
        end
      end
      READ_RX: begin
        if (!req) begin
          addr_d = A_RX_DATA;
          ren_d  = 1'b1;
        end else if (done) begin
          ren_d   = 1'b0;
          state_d = POLL_TX;
          if (!bus_error) begin
            hold_d  = rdata[7:0];
            state_d = HOLD_RX;
          end
        end
      end
      HOLD_RX: begin
        if (rx_ready) state_d = POLL_TX;
      end
      POLL_TX: begin
        if (!req) begin
          if (!tx_valid) begin
            state_d = POLL_RX;
          end else begin
            addr_d = A_TX_STATE;
            ren_d  = 1'b1;
          end
        end else if (done) begin
          ren_d   = 1'b0;
          state_d = (!bus_error && (rdata[2:0] <= TX_HIGH)) ? WRITE_TX : POLL_RX;
        end
      end
      WRITE_TX: begin
        if (!req) begin
          addr_d  = A_TX_DATA;
          wdata_d = {24'b0, tx_data};
          wen_d   = 1'b1;
        end else if (done) begin
          wen_d    = 1'b0;
          tx_ready = 1'b1;
          state_d  = POLL_RX;
        end
      end
      default: ;
    endcase

    if (done && bus_error) err_d = 1'b1;

`ifdef UART_HOST_TIMEOUT_EN
    if (done) begin
      tcnt_d = '0;
    end else if (req) begin
      if (tcnt_q == TO_LAST) begin
        tcnt_d    = '0;
        wen_d     = 1'b0;
        ren_d     = 1'b0;
        timeout_d = 1'b1;
        err_d     = 1'b1;
        state_d   = ready_q ? POLL_RX : RESET_WAIT;
      end else begin
        tcnt_d = tcnt_q + 16'd1;
      end
    end
`endif

    if (cfg_start) begin
      state_d  = CLR;
      wen_d    = 1'b0;
      ren_d    = 1'b0;
      ready_d  = 1'b0;
      rx_err_d = 1'b0;
      err_d    = 1'b0;
`ifdef UART_HOST_TIMEOUT_EN
      tcnt_d   = '0;
`endif
    end
  end
endmodule

// File: tb/tb_uart_bus_host.sv
// tb/tb_uart_bus_host.sv - scoreboard bench for uart_bus_host
module tb_uart_bus_host;
  localparam int TO_CYC = 16;

  logic        clk = 1'b0;
  logic        nReset, cfg_start, cfg_flow, tx_valid, tx_ready, rx_valid, rx_ready;
  logic [15:0] cfg_rate;
  logic [7:0]  tx_data, rx_data;
  logic [31:0] addr, wdata, rdata;
  logic        wen, ren, request_stall, bus_error, ready, rx_err, err, timeout;

  logic [31:0] rx_state_v, rx_data_v, tx_state_v;

  typedef struct packed {
    logic [31:0] addr;
    logic        w;
    logic [31:0] data;
  } acc_t;

  acc_t       exp_q[$];
  logic [7:0] rx_exp[$];
  acc_t       e_mon;
  logic [7:0] b_mon;
  int         total = 0;
  int         bad = 0;
  int         poll12 = 0;

  always #5 clk = ~clk;

  assign rdata = !ren ? 32'h0 :
                 (addr == 32'd0)  ? rx_data_v :
                 (addr == 32'd8)  ? rx_state_v :
                 (addr == 32'd12) ? tx_state_v : 32'h0;

  uart_bus_host #(.TxHighWater(6), .TimeoutCycles(TO_CYC)) dut (
    .clk(clk), .nReset(nReset), .cfg_start(cfg_start), .cfg_rate(cfg_rate),
    .cfg_flow(cfg_flow), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .addr(addr),
    .wen(wen), .ren(ren), .wdata(wdata), .rdata(rdata), .request_stall(request_stall),
    .bus_error(bus_error), .ready(ready), .rx_err(rx_err), .err(err), .timeout(timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_init(input logic [15:0] rate, input logic flow);
    exp_q.push_back('{addr: 32'd20, w: 1'b1, data: 32'd1});
    exp_q.push_back('{addr: 32'd16, w: 1'b1, data: {16'b0, rate}});
    exp_q.push_back('{addr: 32'd24, w: 1'b1, data: {31'b0, flow}});
  endtask

  task automatic wait_ready(input string name);
    int g;
    g = 0;
    while (!ready && g < 40) begin
      tick();
      g++;
    end
    check(name, 32'(ready), 32'd1);
  endtask

  // Monitor: every completed non-poll access and every RX transfer is checked in order.
  always @(negedge clk) begin
    if (nReset) begin
      if ((wen || ren) && !request_stall) begin
        if (ren && addr == 32'd8) begin
        end else if (ren && addr == 32'd12) begin
          poll12++;
        end else if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL bus_unexpected: got addr=%h wen=%b wdata=%h want no access", addr, wen, wdata);
        end else begin
          e_mon = exp_q.pop_front();
          check("bus_addr", addr, e_mon.addr);
          check("bus_wen", 32'(wen), 32'(e_mon.w));
          if (e_mon.w) check("bus_wdata", wdata, e_mon.data);
        end
      end
      if (rx_valid && rx_ready) begin
        if (rx_exp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got %h want no transfer", rx_data);
        end else begin
          b_mon = rx_exp.pop_front();
          check("rx_byte", 32'(rx_data), 32'(b_mon));
        end
      end
    end
  end

  initial begin
    int cyc, n, g, p0;
    nReset = 1'b0; cfg_start = 1'b0; cfg_rate = '0; cfg_flow = 1'b0;
    tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0; request_stall = 1'b0;
    bus_error = 1'b0; rx_state_v = '0; rx_data_v = '0; tx_state_v = '0;
    repeat (3) tick();
    check("rst_addr", addr, 32'd0);
    check("rst_req", 32'({wen, ren}), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_flags", 32'({err, rx_err, timeout, tx_ready}), 32'd0);
    nReset = 1'b1;
    tick();
    check("idle_no_req", 32'({wen, ren}), 32'd0);

    // Init sequence and its latency
    cfg_rate = 16'h1457; cfg_flow = 1'b0;
    push_init(16'h1457, 1'b0);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cyc = 1;
    while (!ready && cyc < 30) begin
      tick();
      cyc++;
    end
    check("init_ready_cycle", 32'(cyc), 32'd7);

    // Idle loop: one RX_STATE read every two cycles
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (ren && addr == 32'd8) n++;
      check("idle_no_write", 32'(wen), 32'd0);
      tick();
    end
    check("idle_poll_rate", 32'(n), 32'd4);

    // RX byte held until the client accepts it
    rx_data_v = 32'h5A; rx_state_v = 32'h0A;
    exp_q.push_back('{addr: 32'd0, w: 1'b0, data: 32'd0});
    rx_exp.push_back(8'h5A);
    g = 0;
    while (!rx_valid && g < 30) begin
      tick();
      g++;
    end
    check("rx_valid_seen", 32'(rx_valid), 32'd1);
    rx_state_v = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("rx_hold_valid", 32'(rx_valid), 32'd1);
      check("rx_hold_data", 32'(rx_data), 32'h5A);
      check("rx_hold_bus", 32'({wen, ren}), 32'd0);
      tick();
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("rx_valid_drop", 32'(rx_valid), 32'd0);

    // TX with room in the peripheral FIFO
    tx_state_v = 32'd3; tx_data = 8'hC3; tx_valid = 1'b1;
    exp_q.push_back('{addr: 32'd4, w: 1'b1, data: 32'hC3});
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_ready) begin
        n++;
        tick();
        tx_valid = 1'b0;
      end else begin
        tick();
      end
    end
    check("tx_ready_pulses", 32'(n), 32'd1);

    // TX with the FIFO above the high-water mark: polled but never written
    p0 = poll12;
    tx_state_v = 32'd7; tx_data = 8'h99; tx_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_ready) n++;
      tick();
    end
    tx_valid = 1'b0;
    check("tx_full_no_ready", 32'(n), 32'd0);
    check("tx_full_polled", 32'(poll12 > p0), 32'd1);
    repeat (4) tick();

    // Re-init with a stalled BAUD_RATE write
    cfg_rate = 16'h00AB; cfg_flow = 1'b1;
    push_init(16'h00AB, 1'b1);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("cfg_abort_drop", 32'({wen, ren}), 32'd0);
    check("cfg_ready_clear", 32'(ready), 32'd0);
    g = 0;
    while (!(wen && addr == 32'd16) && g < 30) begin
      tick();
      g++;
    end
    check("baud_req_seen", 32'(wen && addr == 32'd16), 32'd1);
    request_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("stall_wen", 32'(wen), 32'd1);
      check("stall_addr", addr, 32'd16);
      check("stall_wdata", wdata, 32'h00AB);
      tick();
    end
    request_stall = 1'b0;
    wait_ready("stall_ready");

    // Sticky error flags and their clearing by cfg_start
    rx_state_v = 32'h10;
    g = 0;
    while (!rx_err && g < 30) begin
      tick();
      g++;
    end
    check("rx_err_set", 32'(rx_err), 32'd1);
    rx_state_v = 32'h0;
    bus_error = 1'b1;
    g = 0;
    while (!err && g < 30) begin
      tick();
      g++;
    end
    bus_error = 1'b0;
    check("err_set", 32'(err), 32'd1);
    check("rx_err_kept", 32'(rx_err), 32'd1);
    push_init(16'h00AB, 1'b1);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("cfg_clears_flags", 32'({rx_err, err}), 32'd0);
    wait_ready("reinit_ready");

`ifdef UART_HOST_TIMEOUT_EN
    g = 0;
    while (!ren && g < 30) begin
      tick();
      g++;
    end
    request_stall = 1'b1;
    n = 0;
    while (!timeout && n < 60) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TO_CYC));
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_drop_req", 32'({wen, ren}), 32'd0);
    request_stall = 1'b0;
    g = 0;
    while (!(ren && addr == 32'd8) && g < 30) begin
      tick();
      g++;
    end
    check("timeout_resume", 32'(ren && addr == 32'd8), 32'd1);
`endif

    repeat (10) tick();
    check("timeout_idle", 32'(timeout), 32'd0);
    check("bus_queue_empty", 32'(exp_q.size()), 32'd0);
    check("rx_queue_empty", 32'(rx_exp.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
